// File: rtl/cla_pipe_alu_add.sv
// Pipelined carry-lookahead adder/subtractor: one BLK-bit lookahead block per stage,
// carries ripple stage-to-stage through registers, whole-pipe valid/ready stall.
module cla_pipe_alu_add #(
    parameter int WIDTH = 8,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             v_out,
    output logic             z_out,
    output logic             n_out
);

    localparam int NBLK = WIDTH / BLK;

    generate
        if ((BLK < 1) || ((WIDTH % BLK) != 0)) begin : g_param_chk
            $error("cla_pipe_alu_add: WIDTH must be a positive multiple of BLK");
        end
    endgenerate

    // Returns {carry out, carry into block MSB, block sum}.
    function automatic logic [BLK+1:0] cla_blk(input logic [BLK-1:0] x,
                                               input logic [BLK-1:0] y,
                                               input logic           ci);
        logic [BLK-1:0] p;
        logic [BLK-1:0] g;
        logic [BLK:0]   c;
        p    = x ^ y;
        g    = x & y;
        c    = {(BLK+1){1'b0}};
        c[0] = ci;
        for (int i = 0; i < BLK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[BLK], c[BLK-1], p ^ c[BLK-1:0]};
    endfunction

    logic                 adv_s;
    logic [WIDTH-1:0]     b_prep_s;
    logic                 c0_s;
    logic [WIDTH-1:0]     stg_a_s   [NBLK];
    logic [WIDTH-1:0]     stg_b_s   [NBLK];
    logic [WIDTH-1:0]     stg_sum_s [NBLK];
    logic [NBLK-1:0]      stg_v_s;
    logic [NBLK-1:0]      stg_c_s;
    logic [BLK+1:0]       blk_s     [NBLK];
    logic [WIDTH-1:0]     nxt_a_s   [NBLK];
    logic [WIDTH-1:0]     nxt_b_s   [NBLK];
    logic [WIDTH-1:0]     nxt_sum_s [NBLK];
    logic [NBLK-1:0]      nxt_c_s;
    logic                 v_nxt_s;
    logic                 z_nxt_s;
    logic                 n_nxt_s;
    logic [WIDTH-1:0]     pipe_a_r  [NBLK];
    logic [WIDTH-1:0]     pipe_b_r  [NBLK];
    logic [WIDTH-1:0]     pipe_sum_r[NBLK];
    logic [NBLK-1:0]      pipe_v_r;
    logic [NBLK-1:0]      pipe_c_r;
    logic                 v_r;
    logic                 z_r;
    logic                 n_r;

    // Operand preparation and the global advance condition.
    always_comb begin
        b_prep_s = op[0] ? ~b : b;
        c0_s     = op[1] ? cin : op[0];
        adv_s    = ~pipe_v_r[NBLK-1] | out_ready;
    end

    // Stage inputs: stage 0 from the ports, stage k from the registers of stage k-1.
    always_comb begin
        stg_v_s = {NBLK{1'b0}};
        stg_c_s = {NBLK{1'b0}};
        for (int k = 0; k < NBLK; k++) begin
            stg_a_s[k]   = {WIDTH{1'b0}};
            stg_b_s[k]   = {WIDTH{1'b0}};
            stg_sum_s[k] = {WIDTH{1'b0}};
        end
        stg_a_s[0] = a;
        stg_b_s[0] = b_prep_s;
        stg_v_s[0] = in_valid;
        stg_c_s[0] = c0_s;
        for (int k = 1; k < NBLK; k++) begin
            stg_a_s[k]   = pipe_a_r[k-1];
            stg_b_s[k]   = pipe_b_r[k-1];
            stg_sum_s[k] = pipe_sum_r[k-1];
            stg_v_s[k]   = pipe_v_r[k-1];
            stg_c_s[k]   = pipe_c_r[k-1];
        end
    end

    // Per-stage block evaluation; consumed operand slices are cleared as they complete.
    always_comb begin
        nxt_c_s = {NBLK{1'b0}};
        for (int k = 0; k < NBLK; k++) begin
            blk_s[k]     = cla_blk(stg_a_s[k][k*BLK +: BLK], stg_b_s[k][k*BLK +: BLK], stg_c_s[k]);
            nxt_sum_s[k] = stg_sum_s[k];
            nxt_sum_s[k][k*BLK +: BLK] = blk_s[k][BLK-1:0];
            nxt_a_s[k]   = stg_a_s[k];
            nxt_a_s[k][k*BLK +: BLK] = {BLK{1'b0}};
            nxt_b_s[k]   = stg_b_s[k];
            nxt_b_s[k][k*BLK +: BLK] = {BLK{1'b0}};
            nxt_c_s[k]   = blk_s[k][BLK+1];
        end
        v_nxt_s = blk_s[NBLK-1][BLK+1] ^ blk_s[NBLK-1][BLK];
        z_nxt_s = (nxt_sum_s[NBLK-1] == {WIDTH{1'b0}});
        n_nxt_s = nxt_sum_s[NBLK-1][WIDTH-1];
    end

    // Pipeline registers; data only loads behind a valid bundle so idle outputs hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v_r <= {NBLK{1'b0}};
            pipe_c_r <= {NBLK{1'b0}};
            for (int k = 0; k < NBLK; k++) begin
                pipe_a_r[k]   <= {WIDTH{1'b0}};
                pipe_b_r[k]   <= {WIDTH{1'b0}};
                pipe_sum_r[k] <= {WIDTH{1'b0}};
            end
            v_r <= 1'b0;
            z_r <= 1'b0;
            n_r <= 1'b0;
        end else if (adv_s) begin
            for (int k = 0; k < NBLK; k++) begin
                pipe_v_r[k] <= stg_v_s[k];
                if (stg_v_s[k]) begin
                    pipe_a_r[k]   <= nxt_a_s[k];
                    pipe_b_r[k]   <= nxt_b_s[k];
                    pipe_sum_r[k] <= nxt_sum_s[k];
                    pipe_c_r[k]   <= nxt_c_s[k];
                end
            end
            if (stg_v_s[NBLK-1]) begin
                v_r <= v_nxt_s;
                z_r <= z_nxt_s;
                n_r <= n_nxt_s;
            end
        end
    end

    assign in_ready  = adv_s;
    assign out_valid = pipe_v_r[NBLK-1];
    assign sum       = pipe_sum_r[NBLK-1];
    assign c_out     = pipe_c_r[NBLK-1];
    assign v_out     = v_r;
    assign z_out     = z_r;
    assign n_out     = n_r;

endmodule

// File: tb/tb_cla_pipe_alu_add.sv
// Bench for cla_pipe_alu_add: three configurations (8/4, 16/4, 8/8) share one random
// stimulus stream, each with its own arithmetic reference scoreboard.
module tb_cla_pipe_alu_add;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;

    logic        ir0, ov0, c0o, v0o, z0o, n0o;
    logic [7:0]  s0;
    logic        ir1, ov1, c1o, v1o, z1o, n1o;
    logic [15:0] s1;
    logic        ir2, ov2, c2o, v2o, z2o, n2o;
    logic [7:0]  s2;

    int          checks = 0;
    int          errors = 0;
    int          acc[3];
    int          ret[3];
    int          wp[3];
    int          rp[3];
    logic [19:0] fifo[3][64];

    always #5 clk = ~clk;

    cla_pipe_alu_add #(.WIDTH(8), .BLK(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .a(a[7:0]), .b(b[7:0]),
        .op(op), .cin(cin), .out_valid(ov0), .out_ready(out_ready), .sum(s0),
        .c_out(c0o), .v_out(v0o), .z_out(z0o), .n_out(n0o));

    cla_pipe_alu_add #(.WIDTH(16), .BLK(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
        .op(op), .cin(cin), .out_valid(ov1), .out_ready(out_ready), .sum(s1),
        .c_out(c1o), .v_out(v1o), .z_out(z1o), .n_out(n1o));

    cla_pipe_alu_add #(.WIDTH(8), .BLK(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .a(a[7:0]), .b(b[7:0]),
        .op(op), .cin(cin), .out_valid(ov2), .out_ready(out_ready), .sum(s2),
        .c_out(c2o), .v_out(v2o), .z_out(z2o), .n_out(n2o));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int wid(input int d);
        return (d == 1) ? 16 : 8;
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    // {in_ready, out_valid, c, v, z, n, sum16}
    function automatic logic [21:0] obs(input int d);
        case (d)
            0:       return {ir0, ov0, c0o, v0o, z0o, n0o, 8'h00, s0};
            1:       return {ir1, ov1, c1o, v1o, z1o, n1o, s1};
            default: return {ir2, ov2, c2o, v2o, z2o, n2o, 8'h00, s2};
        endcase
    endfunction

    // Reference: plain integer arithmetic; overflow from operand/result signs.
    function automatic logic [19:0] model(input int w, input logic [15:0] aa, input logic [15:0] bb,
                                          input logic [1:0] o, input logic ci);
        int unsigned mask, x, y, c0, tot, s;
        logic sx, sy, ss, v;
        mask = (32'd1 << w) - 32'd1;
        x    = {16'h0000, aa} & mask;
        y    = {16'h0000, bb} & mask;
        if (o[0]) y = mask - y;
        c0   = o[1] ? {31'd0, ci} : {31'd0, o[0]};
        tot  = x + y + c0;
        s    = tot & mask;
        sx   = ((x >> (w - 1)) & 32'd1) != 32'd0;
        sy   = ((y >> (w - 1)) & 32'd1) != 32'd0;
        ss   = ((s >> (w - 1)) & 32'd1) != 32'd0;
        v    = (sx == sy) && (ss != sx);
        return {(tot >> w) != 32'd0, v, s == 32'd0, ss, s[15:0]};
    endfunction

    task automatic sb(input int d);
        logic [21:0] o;
        logic [19:0] e;
        o = obs(d);
        if (rst) begin
            rp[d] = wp[d];
        end else begin
            if (o[20] && out_ready) begin
                if (wp[d] == rp[d]) begin
                    chk($sformatf("sb_underflow_dut%0d", d), wp[d] - rp[d], 1);
                end else begin
                    e = fifo[d][rp[d] % 64];
                    rp[d]++;
                    ret[d]++;
                    chk($sformatf("sb_result_dut%0d", d), {12'h000, o[19:0]}, {12'h000, e});
                end
            end
            if (in_valid && o[21]) begin
                fifo[d][wp[d] % 64] = model(wid(d), a, b, op, cin);
                wp[d]++;
                acc[d]++;
            end
        end
    endtask

    // One cycle: drive at the falling edge, then evaluate the coming rising edge's handshakes.
    task automatic step(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                        input logic [1:0] o, input logic ci, input logic rdy);
        @(negedge clk);
        in_valid  = v;
        a         = aa;
        b         = bb;
        op        = o;
        cin       = ci;
        out_ready = rdy;
        #1;
        for (int d = 0; d < 3; d++) sb(d);
    endtask

    task automatic one_op(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                          input logic [1:0] o, input logic ci, input logic [19:0] exp,
                          output int n);
        step(1'b1, aa, bb, o, ci, 1'b1);
        n = 0;
        do begin
            step(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1);
            n++;
        end while (!ov0 && n < 6);
        chk({tag, "_valid"}, {31'd0, ov0}, 32'd1);
        chk(tag, {12'h000, c0o, v0o, z0o, n0o, 8'h00, s0}, {12'h000, exp});
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 9))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            4:       return 16'h0080;
            5:       return 16'h007F;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          i;
        int          cyc;
        int          base_acc[3];
        int          base_ret[3];
        logic [11:0] held;
        logic [15:0] sa[6];
        logic [15:0] sbv[6];
        logic [1:0]  so[6];

        for (int d = 0; d < 3; d++) begin
            acc[d] = 0; ret[d] = 0; wp[d] = 0; rp[d] = 0;
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0; op = 2'b00; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_outputs", {19'd0, ov0, c0o, v0o, z0o, n0o, s0}, 32'd0);
        chk("reset_in_ready", {31'd0, ir0}, 32'd1);

        one_op("add_7f_01", 16'h007F, 16'h0001, 2'b00, 1'b0, 20'h50080, n);
        chk("add_latency", n, 2);
        one_op("sub_05_05", 16'h0005, 16'h0005, 2'b01, 1'b0, 20'hA0000, n);
        one_op("sub_00_01", 16'h0000, 16'h0001, 2'b01, 1'b1, 20'h100FF, n);
        one_op("adc_ff_00", 16'h00FF, 16'h0000, 2'b10, 1'b1, 20'hA0000, n);
        one_op("sbc_80_01", 16'h0080, 16'h0001, 2'b11, 1'b1, 20'hC007F, n);

        // Back-to-back stream with a three-cycle consumer stall in the middle.
        for (int k = 0; k < 6; k++) begin
            sa[k] = pick(); sbv[k] = pick(); so[k] = 2'($urandom_range(0, 3));
        end
        base_ret[0] = ret[0];
        i = 0; cyc = 0; held = 12'h000;
        while (i < 6 && cyc < 30) begin
            step(1'b1, sa[i], sbv[i], so[i], 1'b1, !(cyc >= 4 && cyc < 7));
            if (cyc >= 4 && cyc < 7) begin
                chk("stall_in_ready", {31'd0, ir0}, 32'd0);
                if (cyc == 4) held = {ov0, c0o, v0o, z0o, s0};
                else chk("stall_hold", {20'd0, ov0, c0o, v0o, z0o, s0}, {20'd0, held});
            end
            if (ir0) i++;
            cyc++;
        end
        repeat (8) step(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
        chk("stream_retired", ret[0] - base_ret[0], 6);

        // Reset with two operations in flight.
        step(1'b1, 16'h1111, 16'h2222, 2'b00, 1'b0, 1'b1);
        step(1'b1, 16'h3333, 16'h4444, 2'b01, 1'b0, 1'b1);
        rst = 1'b1;
        step(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_outputs", {19'd0, ov0, c0o, v0o, z0o, n0o, s0}, 32'd0);
        chk("midreset_in_ready", {31'd0, ir0}, 32'd1);
        one_op("post_reset_add", 16'h0012, 16'h0034, 2'b00, 1'b1, 20'h00046, n);

        // Random valid/ready traffic.
        cyc = 0;
        while ((acc[0] < 10000 || acc[1] < 10000 || acc[2] < 10000) && cyc < 40000) begin
            step($urandom_range(0, 3) != 0, pick(), pick(), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            cyc++;
        end
        chk("random_ops_done", {31'd0, acc[0] >= 10000 && acc[1] >= 10000 && acc[2] >= 10000}, 32'd1);
        repeat (8) step(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);

        // Full-rate streaming with the consumer always ready.
        for (int d = 0; d < 3; d++) begin
            base_acc[d] = acc[d]; base_ret[d] = ret[d];
        end
        repeat (30) begin
            step(1'b1, pick(), pick(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
            chk("rate_in_ready", {29'd0, ir0, ir1, ir2}, 32'd7);
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rate_accepts_dut%0d", d), acc[d] - base_acc[d], 30);
            chk($sformatf("rate_retires_dut%0d", d), ret[d] - base_ret[d], 30 - lat(d));
        end
        repeat (8) step(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("drained_dut%0d", d), wp[d] - rp[d], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
